// File: rtl/dmem_arbiter_if.sv
// Requester-side handshakes for both ports plus the shared data-memory port.
// The slave modport is the arbiter's view; master is the requesters/memory view.
interface dmem_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              m0_req;
    logic              m0_we;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic              m0_done;
    logic              m0_err;
    logic [DATA_W-1:0] m0_rdata;

    logic              m1_req;
    logic              m1_we;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_done;
    logic              m1_err;
    logic [DATA_W-1:0] m1_rdata;

    logic [ADDR_W-1:0] mem_access_addr;
    logic [DATA_W-1:0] mem_write_data;
    logic              mem_write_en;
    logic              mem_read;
    logic [DATA_W-1:0] mem_read_data;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        output m0_done, m0_err, m0_rdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        output m1_done, m1_err, m1_rdata,
        output mem_access_addr, mem_write_data, mem_write_en, mem_read,
        input  mem_read_data
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        input  m0_done, m0_err, m0_rdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        input  m1_done, m1_err, m1_rdata,
        input  mem_access_addr, mem_write_data, mem_write_en, mem_read,
        output mem_read_data
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin two-port sequencer in front of a single-port data memory.
// Done 3 cycles after grant sampling (2 for range errors); requesters hold req until done.
module dmem_arbiter #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int MEM_BYTES = 512
) (
    input  logic          clk,
    input  logic          reset,
    dmem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] MEM_LIMIT = ADDR_W'(MEM_BYTES);

    state_t            state_q, state_d;
    logic              last_q, last_d;
    logic              win_q, win_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic              gnt;

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        win_d    = win_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        we_d     = we_q;
        err_d    = err_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        gnt      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.m0_req || bus.m1_req) begin
                    // On a tie the port that did not win last time gets the slot.
                    gnt     = (bus.m0_req && bus.m1_req) ? ~last_q : bus.m1_req;
                    win_d   = gnt;
                    last_d  = gnt;
                    addr_d  = gnt ? bus.m1_addr  : bus.m0_addr;
                    wdata_d = gnt ? bus.m1_wdata : bus.m0_wdata;
                    we_d    = gnt ? bus.m1_we    : bus.m0_we;
                    if (addr_d < MEM_LIMIT) begin
                        err_d   = 1'b0;
                        state_d = S_ACCESS;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_RESP;
                        if (gnt) begin
                            rdata1_d = '0;
                        end else begin
                            rdata0_d = '0;
                        end
                    end
                end
            end
            S_ACCESS: begin
                if (!we_q) begin
                    if (win_q) begin
                        rdata1_d = bus.mem_read_data;
                    end else begin
                        rdata0_d = bus.mem_read_data;
                    end
                end
                state_d = S_RESP;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            last_q   <= 1'b1;
            win_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            err_q    <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            win_q    <= win_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            we_q     <= we_d;
            err_q    <= err_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    // Strobes and done are decoded from registered state only, so they cannot glitch.
    assign bus.mem_access_addr = addr_q;
    assign bus.mem_write_data  = wdata_q;
    assign bus.mem_write_en    = (state_q == S_ACCESS) &&  we_q;
    assign bus.mem_read        = (state_q == S_ACCESS) && !we_q;

    assign bus.m0_done  = (state_q == S_RESP) && !win_q;
    assign bus.m1_done  = (state_q == S_RESP) &&  win_q;
    assign bus.m0_err   = bus.m0_done && err_q;
    assign bus.m1_err   = bus.m1_done && err_q;
    assign bus.m0_rdata = rdata0_q;
    assign bus.m1_rdata = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vector table, arbitration/reset sequences,
// then random single-port traffic against a word-array reference model.
module tb_dmem_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    dmem_arbiter_if #(.DATA_W(32), .ADDR_W(32)) bus ();

    dmem_arbiter #(.DATA_W(32), .ADDR_W(32), .MEM_BYTES(512)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Behavioural single-port memory with combinational read.
    logic [31:0] mem [0:127] = '{default: 32'h0};
    assign bus.mem_read_data = mem[bus.mem_access_addr[8:2]];
    always @(posedge clk) begin
        if (bus.mem_write_en) mem[bus.mem_access_addr[8:2]] <= bus.mem_write_data;
    end

    int strobe_clash = 0;
    always @(negedge clk) begin
        if (bus.mem_write_en && bus.mem_read) strobe_clash++;
    end

    // Reference model state.
    logic [31:0] ref_mem [0:127] = '{default: 32'h0};
    logic [31:0] ref_rd [0:1] = '{32'h0, 32'h0};

    typedef struct {
        int          port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
        logic [31:0] exp_other;
        int          exp_lat;
    } vec_t;

    vec_t vecs [0:9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_port(input int p, input logic req, input logic we,
                            input logic [31:0] addr, input logic [31:0] wd);
        if (p == 0) begin
            bus.m0_req = req; bus.m0_we = we; bus.m0_addr = addr; bus.m0_wdata = wd;
        end else begin
            bus.m1_req = req; bus.m1_we = we; bus.m1_addr = addr; bus.m1_wdata = wd;
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        ref_rd[0] = 32'h0;
        ref_rd[1] = 32'h0;
    endtask

    // One transaction on port p; req held until done, inputs scrambled after the grant.
    task automatic do_txn(input int p, input logic we, input logic [31:0] addr,
                          input logic [31:0] wd, output logic err, output logic [31:0] rd,
                          output logic [31:0] other, output int lat, output int nwr,
                          output int nrd, output int slat);
        logic dn;
        @(posedge clk); #1;
        set_port(p, 1'b1, we, addr, wd);
        lat = 0; nwr = 0; nrd = 0; slat = 0; err = 1'b0; rd = '0; other = '0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (bus.mem_write_en) begin nwr++; slat = c; end
            if (bus.mem_read)     begin nrd++; slat = c; end
            dn = (p == 0) ? bus.m0_done : bus.m1_done;
            if (dn) begin
                lat   = c;
                err   = (p == 0) ? bus.m0_err   : bus.m1_err;
                rd    = (p == 0) ? bus.m0_rdata : bus.m1_rdata;
                other = (p == 0) ? bus.m1_rdata : bus.m0_rdata;
                break;
            end
            if (c >= 2) set_port(p, 1'b1, ~we, $urandom, $urandom);
        end
        @(posedge clk); #1;
        set_port(p, 1'b0, 1'b0, 32'h0, 32'h0);
        if (we && addr < 32'd512) ref_mem[addr[8:2]] = wd;
    endtask

    task automatic chk_strobes(input string tag, input logic we, input logic err,
                               input int nwr, input int nrd, input int slat);
        if (err) begin
            chk({tag, "_no_strobe"}, {nwr[7:0], nrd[7:0]}, 16'h0);
        end else begin
            chk({tag, "_strobe_cnt"}, {nwr[7:0], nrd[7:0]}, we ? 16'h0100 : 16'h0001);
            chk({tag, "_strobe_cycle"}, slat, 2);
        end
    endtask

    logic        t_err;
    logic [31:0] t_rd, t_oth;
    int          t_lat, t_nwr, t_nrd, t_slat;

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    initial begin
        int   order [$];
        int   dcyc  [$];
        int   both, stray;
        logic [31:0] r0, r1;

        vecs[0] = '{0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000, 32'h0000_0000, 3};
        vecs[1] = '{0, 1'b0, 32'h0000_0010, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF, 32'h0000_0000, 3};
        vecs[2] = '{1, 1'b1, 32'h0000_0100, 32'hA5A5_0001, 1'b0, 32'h0000_0000, 32'hDEAD_BEEF, 3};
        vecs[3] = '{1, 1'b1, 32'h0000_0200, 32'h0000_0001, 1'b1, 32'h0000_0000, 32'hDEAD_BEEF, 2};
        vecs[4] = '{1, 1'b0, 32'h0000_0100, 32'h0000_0000, 1'b0, 32'hA5A5_0001, 32'hDEAD_BEEF, 3};
        vecs[5] = '{0, 1'b1, 32'h0000_01FC, 32'h1234_5678, 1'b0, 32'hDEAD_BEEF, 32'hA5A5_0001, 3};
        vecs[6] = '{1, 1'b0, 32'h0000_01FF, 32'h0000_0000, 1'b0, 32'h1234_5678, 32'hDEAD_BEEF, 3};
        vecs[7] = '{0, 1'b0, 32'hFFFF_0010, 32'h0000_0000, 1'b1, 32'h0000_0000, 32'h1234_5678, 2};
        vecs[8] = '{0, 1'b0, 32'h0000_0010, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF, 32'h1234_5678, 3};
        vecs[9] = '{1, 1'b1, 32'h0000_01FF, 32'h0000_CAFE, 1'b0, 32'h1234_5678, 32'hDEAD_BEEF, 3};

        set_port(0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_port(1, 1'b0, 1'b0, 32'h0, 32'h0);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ctrl", {bus.m0_done, bus.m1_done, bus.m0_err, bus.m1_err,
                         bus.mem_write_en, bus.mem_read}, 64'h0);
        chk("rst_rdata", {bus.m0_rdata, bus.m1_rdata}, 64'h0);
        chk("rst_membus", {bus.mem_access_addr, bus.mem_write_data}, 64'h0);
        @(posedge clk); #1;
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            do_txn(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                   t_err, t_rd, t_oth, t_lat, t_nwr, t_nrd, t_slat);
            chk($sformatf("vec%0d_lat", i), t_lat, vecs[i].exp_lat);
            chk($sformatf("vec%0d_err", i), t_err, vecs[i].exp_err);
            chk($sformatf("vec%0d_rdata", i), t_rd, vecs[i].exp_rdata);
            chk($sformatf("vec%0d_other_rdata", i), t_oth, vecs[i].exp_other);
            chk_strobes($sformatf("vec%0d", i), vecs[i].we, vecs[i].exp_err, t_nwr, t_nrd, t_slat);
        end

        // Simultaneous requests right after reset, each dropped after its own done.
        do_txn(1, 1'b1, 32'h4, 32'h44, t_err, t_rd, t_oth, t_lat, t_nwr, t_nrd, t_slat);
        do_txn(0, 1'b1, 32'h8, 32'h88, t_err, t_rd, t_oth, t_lat, t_nwr, t_nrd, t_slat);
        do_reset();
        @(posedge clk); #1;
        set_port(0, 1'b1, 1'b0, 32'h4, 32'h0);
        set_port(1, 1'b1, 1'b0, 32'h8, 32'h0);
        both = 0; r0 = '0; r1 = '0;
        for (int c = 1; c <= 10; c++) begin
            logic d0, d1;
            @(negedge clk);
            d0 = bus.m0_done; d1 = bus.m1_done;
            if (d0 && d1) both++;
            if (d0) begin order.push_back(0); dcyc.push_back(c); r0 = bus.m0_rdata; end
            if (d1) begin order.push_back(1); dcyc.push_back(c); r1 = bus.m1_rdata; end
            @(posedge clk); #1;
            if (d0) set_port(0, 1'b0, 1'b0, 32'h0, 32'h0);
            if (d1) set_port(1, 1'b0, 1'b0, 32'h0, 32'h0);
        end
        chk("tie_done_count", order.size(), 2);
        if (order.size() == 2) begin
            chk("tie_order", {order[0][3:0], order[1][3:0]}, 8'h01);
            chk("tie_done_cycles", {dcyc[0][7:0], dcyc[1][7:0]}, 16'h0306);
        end
        chk("tie_rdata", {r0, r1}, {32'h44, 32'h88});

        // Both held continuously: grants alternate, one done per 3 cycles.
        do_reset();
        order.delete(); dcyc.delete();
        @(posedge clk); #1;
        set_port(0, 1'b1, 1'b0, 32'h4, 32'h0);
        set_port(1, 1'b1, 1'b0, 32'h8, 32'h0);
        for (int c = 1; c <= 21; c++) begin
            @(negedge clk);
            if (bus.m0_done && bus.m1_done) both++;
            if (bus.m0_done) begin order.push_back(0); dcyc.push_back(c); end
            if (bus.m1_done) begin order.push_back(1); dcyc.push_back(c); end
            if (c == 18) begin
                @(posedge clk); #1;
                set_port(0, 1'b0, 1'b0, 32'h0, 32'h0);
                set_port(1, 1'b0, 1'b0, 32'h0, 32'h0);
            end
        end
        chk("rr_done_count", order.size(), 6);
        for (int k = 0; k < order.size() && k < 6; k++) begin
            chk($sformatf("rr_grant%0d_port", k), order[k], k % 2);
            chk($sformatf("rr_grant%0d_cycle", k), dcyc[k], 3 * (k + 1));
        end
        chk("no_double_done", both, 0);

        // Reset landing on the ACCESS edge of a write.
        @(posedge clk); #1;
        set_port(0, 1'b1, 1'b1, 32'h20, 32'h55);
        @(negedge clk);
        @(negedge clk);
        chk("rstmid_write_strobe", bus.mem_write_en, 1'b1);
        reset = 1'b1;
        set_port(0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk("rstmid_ctrl", {bus.m0_done, bus.m1_done, bus.m0_err, bus.m1_err,
                            bus.mem_write_en, bus.mem_read}, 64'h0);
        chk("rstmid_rdata", {bus.m0_rdata, bus.m1_rdata}, 64'h0);
        chk("rstmid_membus", {bus.mem_access_addr, bus.mem_write_data}, 64'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        ref_rd[0] = 32'h0;
        ref_rd[1] = 32'h0;
        ref_mem[8] = 32'h55;
        stray = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (bus.m0_done || bus.m1_done) stray++;
        end
        chk("rstmid_no_done", stray, 0);
        do_txn(0, 1'b0, 32'h20, 32'h0, t_err, t_rd, t_oth, t_lat, t_nwr, t_nrd, t_slat);
        chk("rstmid_readback", t_rd, 32'h55);

        // Random single-port traffic against the reference model.
        do_reset();
        for (int i = 0; i < 60; i++) begin
            int          p, sel, elat;
            logic        we, eerr;
            logic [31:0] a, wd, erd, eoth;
            p   = $urandom_range(0, 1);
            we  = 1'($urandom_range(0, 1));
            sel = $urandom_range(0, 9);
            if (sel < 7)       a = $urandom_range(0, 511);
            else if (sel == 7) a = ($urandom_range(0, 1) == 0) ? 32'd511 : 32'd512;
            else               a = $urandom | 32'h0001_0000;
            wd   = $urandom;
            eerr = (a >= 32'd512);
            elat = eerr ? 2 : 3;
            if (eerr)    erd = 32'h0;
            else if (we) erd = ref_rd[p];
            else         erd = ref_mem[a / 4];
            eoth = ref_rd[1 - p];
            do_txn(p, we, a, wd, t_err, t_rd, t_oth, t_lat, t_nwr, t_nrd, t_slat);
            ref_rd[p] = erd;
            chk($sformatf("rnd%0d_lat", i), t_lat, elat);
            chk($sformatf("rnd%0d_err", i), t_err, eerr);
            chk($sformatf("rnd%0d_rdata", i), t_rd, erd);
            chk($sformatf("rnd%0d_other_rdata", i), t_oth, eoth);
            chk_strobes($sformatf("rnd%0d", i), we, eerr, t_nwr, t_nrd, t_slat);
        end

        chk("strobe_exclusive", strobe_clash, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
